rasterizer_arbiter: RTL and testbench
=====================================

RASTERIZER_ARBITER -- requirements
Module: rasterizer_arbiter

Interface
REQ-001 The block SHALL have parameter VERTS_PER_TRI, default 3, meaning vertex transfers per triangle (lock length).
REQ-002 Ports SHALL be `clk_in`, input, 1 bit: the single clock.
REQ-003 `rst_n_in`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 `req0_valid_in` in 1, `req0_ready_out` out 1, `req0_vertex_in` in 128 ([3:0][31:0] float x,y,z,w), `req0_material_in` in 12: requester 0 vertex stream.
REQ-005 `req1_valid_in` in 1, `req1_ready_out` out 1, `req1_vertex_in` in 128, `req1_material_in` in 12: requester 1 vertex stream, same format.
REQ-006 `rast_valid_out` out 1, `rast_ready_in` in 1, `rast_vertex_out` out 128, `rast_material_out` out 12: stream to the rasterizer vertex port.
REQ-007 `grant_out` out 2: one-hot current owner; 2'b00 when idle.
REQ-008 `tri_count_out` out 16: triangles fully forwarded since reset.

Function
REQ-009 Transfer on a port SHALL occur on a rising edge where valid and ready are both 1.
REQ-010 FSM SHALL have states IDLE, OWN0 and OWN1, plus a 1-bit priority pointer `prio` (0 = requester 0 preferred).
REQ-011 IDLE: if exactly one `reqN_valid_in`=1, next state SHALL be OWNN; if both, OWN[prio]; if none, stay IDLE.
REQ-012 In IDLE all `reqN_ready_out` and `rast_valid_out` SHALL be 0; grant latency from first valid to owner SHALL be exactly 1 cycle.
REQ-013 In OWNN, `rast_valid_out`, `rast_vertex_out` and `rast_material_out` SHALL combinationally equal requester N's inputs.
REQ-014 In OWNN, `reqN_ready_out` SHALL equal `rast_ready_in`; the non-owner ready SHALL be 0.
REQ-015 A 2-bit counter `vcnt`, cleared on entering OWNN, SHALL increment on each rasterizer-port transfer.
REQ-016 The transfer with `vcnt`=VERTS_PER_TRI-1 SHALL, at that edge:
- return the FSM to IDLE;
- clear `vcnt`;
- set `prio` to the non-owner index;
- increment `tri_count_out`, wrapping 16'hFFFF to 0.
REQ-017 Ownership SHALL be locked until the triangle completes; owner deasserting valid mid-triangle SHALL NOT release the grant or let the other requester transfer.
REQ-018 While in OWNN, the other requester's valid SHALL be ignored; it is served at the next IDLE arbitration.
REQ-019 Round-robin: with both requesters continuously valid, owners SHALL alternate 0,1,0,1 per triangle.
REQ-020 `rast_ready_in` dropping mid-triangle SHALL stall transfers with no state change other than holding.
REQ-021 The block SHALL add no data latency; no vertex or material field SHALL be modified.
REQ-022 `grant_out` SHALL be 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE; it is a registered state decode.

Reset
REQ-023 On `rst_n_in`=0, asynchronously: FSM=IDLE, `prio`=0, `vcnt`=0, `tri_count_out`=0, `grant_out`=0, all ready/valid outputs 0.
REQ-024 Reset mid-triangle SHALL discard the partial triangle silently; the rasterizer is reset by the same system reset.
REQ-025 Leaving reset SHALL take effect on the first rising edge after `rst_n_in` rises; the first arbitration uses `prio`=0.

Verification
REQ-026 Single requester: req0 sends 3 vertices, `rast_ready_in`=1 → `grant_out`=01 one cycle after valid; 3 transfers on consecutive cycles; IDLE next; `tri_count_out`=1.
REQ-027 Contention: both valid from reset, 4 triangles each → owner order 0,1,0,1,…; `tri_count_out`=8; no interleaved vertices within a triangle.
REQ-028 Lock: req0 valid for 1 vertex then deasserts 10 cycles while req1 valid → `req1_ready_out`=0 throughout; req0 completes; req1 granted next.
REQ-029 Backpressure: `rast_ready_in` toggles 1,0,0,1,0,1 during an OWN1 triangle → exactly 3 transfers, data matches req1 inputs, `tri_count_out` increments once.
REQ-030 Reset mid-triangle: assert `rst_n_in`=0 after 2 vertices of OWN0 → outputs 0 immediately (before the next clock edge); after release, a 3-vertex req1 triangle completes normally; `tri_count_out`=1.
REQ-031 Wrap: preload or run 65536 triangles → `tri_count_out` returns to 0.

Source files
------------

// File: rtl/rasterizer_arbiter.sv
// Two-requester vertex-stream arbiter in front of a rasterizer vertex port.
// Once a requester is granted, it keeps the port until it has sent a whole
// triangle (VERTS_PER_TRI transfers). Owners are chosen round-robin.
// Data passes through combinationally, with no added latency.
module rasterizer_arbiter #(
    parameter int          VERTS_PER_TRI = 3,
    parameter logic [15:0] TRI_COUNT_RST = 16'h0000
) (
    input  logic         clk_in,
    input  logic         rst_n_in,

    input  logic         req0_valid_in,
    output logic         req0_ready_out,
    input  logic [127:0] req0_vertex_in,
    input  logic [11:0]  req0_material_in,

    input  logic         req1_valid_in,
    output logic         req1_ready_out,
    input  logic [127:0] req1_vertex_in,
    input  logic [11:0]  req1_material_in,

    output logic         rast_valid_out,
    input  logic         rast_ready_in,
    output logic [127:0] rast_vertex_out,
    output logic [11:0]  rast_material_out,

    output logic [1:0]   grant_out,
    output logic [15:0]  tri_count_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Index of the last vertex of a triangle; its transfer releases the lock.
    localparam logic [1:0] LAST_VERT = 2'(VERTS_PER_TRI - 1);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [1:0]  vcnt_q, vcnt_d;
    logic [15:0] tri_q, tri_d;
    logic [1:0]  grant_q, grant_d;
    logic        xfer_s;

    // Mux the owner's stream to the rasterizer and route its ready back.
    always_comb begin
        rast_valid_out    = 1'b0;
        rast_vertex_out   = 128'h0;
        rast_material_out = 12'h000;
        req0_ready_out    = 1'b0;
        req1_ready_out    = 1'b0;
        case (state_q)
            ST_OWN0: begin
                rast_valid_out    = req0_valid_in;
                rast_vertex_out   = req0_vertex_in;
                rast_material_out = req0_material_in;
                req0_ready_out    = rast_ready_in;
            end
            ST_OWN1: begin
                rast_valid_out    = req1_valid_in;
                rast_vertex_out   = req1_vertex_in;
                rast_material_out = req1_material_in;
                req1_ready_out    = rast_ready_in;
            end
            default: begin
                rast_valid_out = 1'b0;
            end
        endcase
    end

    assign xfer_s = rast_valid_out & rast_ready_in;

    // Arbitration, vertex counting and triangle completion bookkeeping.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        vcnt_d  = vcnt_q;
        tri_d   = tri_q;
        case (state_q)
            ST_IDLE: begin
                // The counter starts every triangle from zero.
                vcnt_d = 2'd0;
                if (req0_valid_in && req1_valid_in) begin
                    state_d = prio_q ? ST_OWN1 : ST_OWN0;
                end else if (req0_valid_in) begin
                    state_d = ST_OWN0;
                end else if (req1_valid_in) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (xfer_s) begin
                    if (vcnt_q == LAST_VERT) begin
                        state_d = ST_IDLE;
                        vcnt_d  = 2'd0;
                        // Prefer the requester that did not just finish.
                        prio_d  = (state_q == ST_OWN0) ? 1'b1 : 1'b0;
                        tri_d   = tri_q + 16'd1;
                    end else begin
                        vcnt_d = vcnt_q + 2'd1;
                    end
                end else begin
                    // A stall or a missing owner vertex holds everything in place.
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vcnt_d  = 2'd0;
            end
        endcase
    end

    // Grant is the decode of the next state, so the registered copy tracks state_q.
    always_comb begin
        case (state_d)
            ST_OWN0: grant_d = 2'b01;
            ST_OWN1: grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    // State and counter registers. Reset drops any partial triangle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            vcnt_q  <= 2'd0;
            tri_q   <= TRI_COUNT_RST;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            vcnt_q  <= vcnt_d;
            tri_q   <= tri_d;
            grant_q <= grant_d;
        end
    end

    assign grant_out     = grant_q;
    assign tri_count_out = tri_q;

endmodule

// File: tb/tb_rasterizer_arbiter.sv
// Directed self-checking bench for rasterizer_arbiter.
// A second instance has its triangle counter preset near the top so that the
// wrap from 16'hFFFF to 0 can be observed in a short run.
module tb_rasterizer_arbiter;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         req0_valid_in, req1_valid_in, rast_ready_in;
    logic [127:0] req0_vertex_in, req1_vertex_in;
    logic [11:0]  req0_material_in, req1_material_in;
    logic         req0_ready_out, req1_ready_out, rast_valid_out;
    logic [127:0] rast_vertex_out;
    logic [11:0]  rast_material_out;
    logic [1:0]   grant_out;
    logic [15:0]  tri_count_out;

    logic         w_req0_ready, w_req1_ready, w_rast_valid;
    logic [127:0] w_rast_vertex;
    logic [11:0]  w_rast_material;
    logic [1:0]   w_grant;
    logic [15:0]  w_tri;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    rasterizer_arbiter dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .req0_valid_in     (req0_valid_in),
        .req0_ready_out    (req0_ready_out),
        .req0_vertex_in    (req0_vertex_in),
        .req0_material_in  (req0_material_in),
        .req1_valid_in     (req1_valid_in),
        .req1_ready_out    (req1_ready_out),
        .req1_vertex_in    (req1_vertex_in),
        .req1_material_in  (req1_material_in),
        .rast_valid_out    (rast_valid_out),
        .rast_ready_in     (rast_ready_in),
        .rast_vertex_out   (rast_vertex_out),
        .rast_material_out (rast_material_out),
        .grant_out         (grant_out),
        .tri_count_out     (tri_count_out)
    );

    rasterizer_arbiter #(.VERTS_PER_TRI(3), .TRI_COUNT_RST(16'hFFFE)) dut_wrap (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .req0_valid_in     (req0_valid_in),
        .req0_ready_out    (w_req0_ready),
        .req0_vertex_in    (req0_vertex_in),
        .req0_material_in  (req0_material_in),
        .req1_valid_in     (req1_valid_in),
        .req1_ready_out    (w_req1_ready),
        .req1_vertex_in    (req1_vertex_in),
        .req1_material_in  (req1_material_in),
        .rast_valid_out    (w_rast_valid),
        .rast_ready_in     (rast_ready_in),
        .rast_vertex_out   (w_rast_vertex),
        .rast_material_out (w_rast_material),
        .grant_out         (w_grant),
        .tri_count_out     (w_tri)
    );

    function automatic logic [127:0] mk_vtx(input logic [7:0] rq, input logic [7:0] ix);
        return {rq, ix, 112'h0123_4567_89AB_CDEF_0011_2233_4455};
    endfunction

    function automatic logic [11:0] mk_mat(input logic [7:0] rq, input logic [7:0] ix);
        return {rq[3:0], ix};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input logic [7:0] ix);
        req0_valid_in    = v;
        req0_vertex_in   = mk_vtx(8'd0, ix);
        req0_material_in = mk_mat(8'd0, ix);
    endtask

    task automatic drive1(input logic v, input logic [7:0] ix);
        req1_valid_in    = v;
        req1_vertex_in   = mk_vtx(8'd1, ix);
        req1_material_in = mk_mat(8'd1, ix);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #1;
        chk("rst_grant", grant_out, 2'b00);
        chk("rst_tri", tri_count_out, 16'd0);
        chk("rst_rvalid", rast_valid_out, 1'b0);
        chk("rst_rdy0", req0_ready_out, 1'b0);
        chk("rst_rdy1", req1_ready_out, 1'b0);
        tick();
        rst_n_in = 1'b1;
    endtask

    initial begin
        logic [5:0] pat;
        int k;
        logic owner;

        rst_n_in = 1'b0;
        rast_ready_in = 1'b1;
        drive0(1'b0, 8'd0);
        drive1(1'b0, 8'd0);
        do_reset();

        // Single requester: grant one cycle after valid, three back-to-back transfers.
        drive0(1'b1, 8'd0);
        settle();
        chk("t1_idle_grant", grant_out, 2'b00);
        chk("t1_idle_rdy0", req0_ready_out, 1'b0);
        chk("t1_idle_rvalid", rast_valid_out, 1'b0);
        tick();
        for (int v = 0; v < 3; v++) begin
            drive0(1'b1, 8'(v));
            settle();
            chk("t1_grant", grant_out, 2'b01);
            chk("t1_rvalid", rast_valid_out, 1'b1);
            chk("t1_vtx", rast_vertex_out, mk_vtx(8'd0, 8'(v)));
            chk("t1_mat", rast_material_out, mk_mat(8'd0, 8'(v)));
            chk("t1_rdy0", req0_ready_out, 1'b1);
            chk("t1_rdy1", req1_ready_out, 1'b0);
            tick();
        end
        drive0(1'b0, 8'd0);
        settle();
        chk("t1_end_grant", grant_out, 2'b00);
        chk("t1_end_tri", tri_count_out, 16'd1);

        // Contention from reset: owners alternate 0,1,0,1 with no interleaving.
        drive0(1'b1, 8'd0);
        drive1(1'b1, 8'd0);
        do_reset();
        for (int t = 0; t < 8; t++) begin
            owner = (t % 2 == 1);
            drive0(1'b1, 8'(t * 3));
            drive1(1'b1, 8'(t * 3));
            settle();
            chk("t2_idle_grant", grant_out, 2'b00);
            tick();
            for (int v = 0; v < 3; v++) begin
                drive0(1'b1, 8'(t * 3 + v));
                drive1(1'b1, 8'(t * 3 + v));
                settle();
                chk("t2_grant", grant_out, owner ? 2'b10 : 2'b01);
                chk("t2_vtx", rast_vertex_out, mk_vtx(owner ? 8'd1 : 8'd0, 8'(t * 3 + v)));
                chk("t2_rdy0", req0_ready_out, !owner);
                chk("t2_rdy1", req1_ready_out, owner);
                tick();
            end
        end
        settle();
        chk("t2_tri", tri_count_out, 16'd8);

        // Lock: owner pauses for 10 cycles, the other requester stays blocked.
        drive0(1'b0, 8'd0);
        drive1(1'b0, 8'd0);
        do_reset();
        drive0(1'b1, 8'h40);
        drive1(1'b1, 8'h50);
        settle();
        tick();
        settle();
        chk("t3_grant", grant_out, 2'b01);
        chk("t3_rdy1", req1_ready_out, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive0(1'b0, 8'h41);
            settle();
            chk("t3_hold_grant", grant_out, 2'b01);
            chk("t3_hold_rdy1", req1_ready_out, 1'b0);
            chk("t3_hold_rvalid", rast_valid_out, 1'b0);
            tick();
        end
        for (int v = 1; v < 3; v++) begin
            drive0(1'b1, 8'(8'h40 + v));
            settle();
            chk("t3_rdy1b", req1_ready_out, 1'b0);
            chk("t3_vtx", rast_vertex_out, mk_vtx(8'd0, 8'(8'h40 + v)));
            tick();
        end
        drive0(1'b0, 8'd0);
        settle();
        chk("t3_end_grant", grant_out, 2'b00);
        chk("t3_end_tri", tri_count_out, 16'd1);
        tick();
        settle();
        chk("t3_next_grant", grant_out, 2'b10);
        chk("t3_next_rdy1", req1_ready_out, 1'b1);

        // Backpressure during an OWN1 triangle.
        drive0(1'b0, 8'd0);
        drive1(1'b0, 8'd0);
        do_reset();
        drive1(1'b1, 8'h60);
        settle();
        tick();
        pat = 6'b101001;   // applied from bit 0 upward: 1,0,0,1,0,1
        k = 0;
        for (int i = 0; i < 6; i++) begin
            rast_ready_in = pat[i];
            drive1(1'b1, 8'(8'h60 + k));
            settle();
            chk("t4_grant", grant_out, 2'b10);
            chk("t4_rdy1", req1_ready_out, pat[i]);
            chk("t4_vtx", rast_vertex_out, mk_vtx(8'd1, 8'(8'h60 + k)));
            chk("t4_mat", rast_material_out, mk_mat(8'd1, 8'(8'h60 + k)));
            tick();
            if (pat[i]) k++;
        end
        drive1(1'b0, 8'd0);
        rast_ready_in = 1'b1;
        settle();
        chk("t4_end_grant", grant_out, 2'b00);
        chk("t4_end_tri", tri_count_out, 16'd1);

        // Reset mid-triangle, then a clean req1 triangle.
        do_reset();
        drive0(1'b1, 8'h70);
        settle();
        tick();
        for (int v = 0; v < 2; v++) begin
            drive0(1'b1, 8'(8'h70 + v));
            settle();
            tick();
        end
        drive0(1'b1, 8'h72);
        rst_n_in = 1'b0;
        #1;
        chk("t5_async_grant", grant_out, 2'b00);
        chk("t5_async_rvalid", rast_valid_out, 1'b0);
        chk("t5_async_rdy0", req0_ready_out, 1'b0);
        chk("t5_async_tri", tri_count_out, 16'd0);
        tick();
        drive0(1'b0, 8'd0);
        drive1(1'b1, 8'h80);
        rst_n_in = 1'b1;
        settle();
        chk("t5_rel_grant", grant_out, 2'b00);
        tick();
        for (int v = 0; v < 3; v++) begin
            drive1(1'b1, 8'(8'h80 + v));
            settle();
            chk("t5_grant", grant_out, 2'b10);
            chk("t5_vtx", rast_vertex_out, mk_vtx(8'd1, 8'(8'h80 + v)));
            tick();
        end
        drive1(1'b0, 8'd0);
        settle();
        chk("t5_end_grant", grant_out, 2'b00);
        chk("t5_end_tri", tri_count_out, 16'd1);
        chk("t6_wrap_ffff", w_tri, 16'hFFFF);

        // One more triangle carries the preset counter over the top.
        drive0(1'b1, 8'h90);
        settle();
        tick();
        for (int v = 0; v < 3; v++) begin
            drive0(1'b1, 8'(8'h90 + v));
            settle();
            tick();
        end
        drive0(1'b0, 8'd0);
        settle();
        chk("t6_tri", tri_count_out, 16'd2);
        chk("t6_wrap_zero", w_tri, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
